// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the fetch/decode/execute controller: opcodes, ALU unit codes,
// FSM states and the decoded-instruction record.
package core_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MULLU = 4'h2;
    localparam logic [3:0] OP_MULHU = 4'h3;
    localparam logic [3:0] OP_MULHS = 4'h4;
    localparam logic [3:0] OP_SHL   = 4'h5;
    localparam logic [3:0] OP_SHR   = 4'h6;
    localparam logic [3:0] OP_LD    = 4'h7;
    localparam logic [3:0] OP_OR    = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_ST    = 4'hB;
    localparam logic [3:0] OP_LDI   = 4'hC;
    localparam logic [3:0] OP_BNEZ  = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] U_ADD  = 3'b000;
    localparam logic [2:0] U_MUL  = 3'b001;
    localparam logic [2:0] U_SHF  = 3'b010;
    localparam logic [2:0] U_LD   = 3'b011;
    localparam logic [2:0] U_OR   = 3'b100;
    localparam logic [2:0] U_XOR  = 3'b101;
    localparam logic [2:0] U_AND  = 3'b110;
    localparam logic [2:0] U_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] unit_sel;
        logic       op_sel;
        logic       seg_sel;
        logic       wb_acc;
        logic       wb_reg;
        logic       is_imm;
        logic       is_br;
        logic       is_halt;
    } dec_t;

endpackage

// File: rtl/core_ctrl_decode.sv
// Combinational opcode decoder: maps IR[7:4] onto ALU selects and writeback/control flags.
module instr_decode
    import core_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.unit_sel = U_PASS;
        case (opcode)
            OP_ADD:   begin dec.unit_sel = U_ADD; dec.wb_acc = 1'b1; end
            OP_SUB:   begin dec.unit_sel = U_ADD; dec.op_sel = 1'b1; dec.wb_acc = 1'b1; end
            OP_MULLU: begin dec.unit_sel = U_MUL; dec.wb_acc = 1'b1; end
            OP_MULHU: begin dec.unit_sel = U_MUL; dec.seg_sel = 1'b1; dec.wb_acc = 1'b1; end
            OP_MULHS: begin
                dec.unit_sel = U_MUL;
                dec.op_sel   = 1'b1;
                dec.seg_sel  = 1'b1;
                dec.wb_acc   = 1'b1;
            end
            OP_SHL:   begin dec.unit_sel = U_SHF; dec.wb_acc = 1'b1; end
            OP_SHR:   begin dec.unit_sel = U_SHF; dec.op_sel = 1'b1; dec.wb_acc = 1'b1; end
            OP_LD:    begin dec.unit_sel = U_LD;  dec.wb_acc = 1'b1; end
            OP_OR:    begin dec.unit_sel = U_OR;  dec.wb_acc = 1'b1; end
            OP_XOR:   begin dec.unit_sel = U_XOR; dec.wb_acc = 1'b1; end
            OP_AND:   begin dec.unit_sel = U_AND; dec.wb_acc = 1'b1; end
            OP_ST:    dec.wb_reg = 1'b1;
            // LDI reuses the load path; the immediate is substituted on the src bus
            OP_LDI:   begin dec.unit_sel = U_LD; dec.is_imm = 1'b1; dec.wb_acc = 1'b1; end
            OP_BNEZ:  dec.is_br = 1'b1;
            OP_NOP:   ;
            OP_HALT:  dec.is_halt = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Fetch/decode/execute controller in front of the ALU: owns PC, IR, ACC, the 16x8 register
// file, BNEZ branching and HALT.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic            imem_req_out,
    output logic [PC_W-1:0] imem_addr_out,
    input  logic            imem_valid_in,
    input  logic [7:0]      imem_data_in,
    output logic [2:0]      alu_unit_sel_out,
    output logic            alu_op_sel_out,
    output logic            alu_mul_seg_sel_out,
    output logic [7:0]      alu_acc_out,
    output logic [7:0]      alu_src_out,
    input  logic [7:0]      alu_res_in,
    output logic [7:0]      acc_out,
    output logic            halt_out
);

    state_e             state;
    logic [PC_W-1:0]    pc;
    logic [7:0]         ir;
    logic [7:0]         acc;
    logic [15:0][7:0]   regs;
    dec_t               dec;
    logic               in_exec;
    logic [PC_W-1:0]    br_off;
    logic [7:0]         reg_rd;

    instr_decode u_dec (
        .opcode (ir[7:4]),
        .dec    (dec)
    );

    assign in_exec = (state == ST_EXEC);
    assign br_off  = {{(PC_W-4){ir[3]}}, ir[3:0]};
    assign reg_rd  = regs[ir[3:0]];

    assign imem_addr_out       = pc;
    assign acc_out             = acc;
    assign alu_acc_out         = acc;
    assign alu_unit_sel_out    = in_exec ? dec.unit_sel : U_PASS;
    assign alu_op_sel_out      = in_exec & dec.op_sel;
    assign alu_mul_seg_sel_out = in_exec & dec.seg_sel;
    assign alu_src_out         = (in_exec && dec.is_imm) ? {4'b0, ir[3:0]} : reg_rd;

    // req is registered, so it is high exactly for the WAIT cycles of each fetch
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= ST_FETCH;
            pc           <= '0;
            ir           <= '0;
            acc          <= '0;
            regs         <= '0;
            imem_req_out <= 1'b0;
            halt_out     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    imem_req_out <= 1'b1;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_valid_in) begin
                        ir           <= imem_data_in;
                        imem_req_out <= 1'b0;
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec.wb_acc) acc <= alu_res_in;
                    if (dec.wb_reg) regs[ir[3:0]] <= acc;
                    // branch offset is relative to the branch's own address
                    if (dec.is_br && (acc != 8'h00)) pc <= pc + br_off;
                    else                             pc <= pc + PC_W'(1);
                    if (dec.is_halt) begin
                        state    <= ST_HALTED;
                        halt_out <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboarded bench for core_ctrl: behavioural ALU + imem with programmable wait count;
// expected per-instruction ALU selects, ACC, PC, halt and CPI are hand-computed.
module tb_core_ctrl;

    typedef struct packed {
        logic [2:0] unit;
        logic       op;
        logic       seg;
        logic [7:0] acc;
        logic [7:0] pc;
        logic       halt;
        logic [7:0] gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req, valid, op, seg, halt;
    logic [7:0] addr, data, acc_alu, src, res, acc;
    logic [2:0] unit;

    logic [7:0] prog [256];
    int         wait_n = 0;
    int         cnt = 0;
    logic       spur = 1'b0;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, last_exec = 0, n_exec = 0;
    int   fetches = 0, viol = 0;
    logic in_exec = 1'b0, post_exec = 1'b0, have_cur = 1'b0;
    logic p_req = 1'b0, p_vld = 1'b0;
    logic [7:0] p_addr = 8'h00;
    exp_t cur;
    exp_t exp_q [$];
    string tag = "init";

    core_ctrl #(.PC_W(8)) dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .imem_req_out        (req),
        .imem_addr_out       (addr),
        .imem_valid_in       (valid),
        .imem_data_in        (data),
        .alu_unit_sel_out    (unit),
        .alu_op_sel_out      (op),
        .alu_mul_seg_sel_out (seg),
        .alu_acc_out         (acc_alu),
        .alu_src_out         (src),
        .alu_res_in          (res),
        .acc_out             (acc),
        .halt_out            (halt)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    logic [15:0] pu, ps;
    always_comb begin
        pu  = {8'h00, acc_alu} * {8'h00, src};
        ps  = $signed({{8{acc_alu[7]}}, acc_alu}) * $signed({{8{src[7]}}, src});
        res = acc_alu;
        case (unit)
            3'b000: res = op ? acc_alu - src : acc_alu + src;
            3'b001: res = op ? (seg ? ps[15:8] : ps[7:0]) : (seg ? pu[15:8] : pu[7:0]);
            3'b010: res = op ? acc_alu >> src[2:0] : acc_alu << src[2:0];
            3'b011: res = src;
            3'b100: res = acc_alu | src;
            3'b101: res = acc_alu ^ src;
            3'b110: res = acc_alu & src;
            default: res = acc_alu;
        endcase
    end

    // Behavioural imem: responds after wait_n request cycles; spur drives stray valids when idle
    assign data  = prog[addr];
    assign valid = req ? (cnt == wait_n) : spur;
    always @(posedge clk) begin
        if (rst)               cnt <= 0;
        else if (req && !valid) cnt <= cnt + 1;
        else                   cnt <= 0;
        cyc       <= cyc + 1;
        in_exec   <= !rst && req && valid;
        post_exec <= !rst && in_exec;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        else n_pass++;
    endtask

    // Scoreboard monitor: pops one expectation per executed instruction
    always @(negedge clk) begin
        if (in_exec) begin
            n_exec++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL %s_extra_exec: got exec at pc %0h, expected none", tag, addr);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                chk($sformatf("%s_sel%0d", tag, n_exec), {29'd0, unit, op, seg},
                    {29'd0, cur.unit, cur.op, cur.seg});
                if (cur.gap != 0)
                    chk($sformatf("%s_cpi%0d", tag, n_exec), cyc - last_exec, {24'd0, cur.gap});
                last_exec = cyc;
            end
        end
        if (post_exec && have_cur) begin
            chk($sformatf("%s_acc%0d", tag, n_exec), {24'd0, acc}, {24'd0, cur.acc});
            chk($sformatf("%s_pc%0d", tag, n_exec), {24'd0, addr}, {24'd0, cur.pc});
            chk($sformatf("%s_halt%0d", tag, n_exec), {31'd0, halt}, {31'd0, cur.halt});
            have_cur = 1'b0;
        end
    end

    // Handshake monitor: req/addr must hold until valid; counts fetches
    always @(negedge clk) begin
        if (rst) begin
            p_req = 1'b0;
            p_vld = 1'b0;
        end else begin
            if (p_req && !p_vld && (!req || addr != p_addr)) viol++;
            if (req && !p_req) fetches++;
            p_req  = req;
            p_vld  = valid;
            p_addr = addr;
        end
    end

    task automatic push(input logic [2:0] u, input logic o, input logic s, input logic [7:0] a,
                        input logic [7:0] p, input logic h, input logic [7:0] g);
        exp_t e;
        e = '{unit: u, op: o, seg: s, acc: a, pc: p, halt: h, gap: g};
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
    endtask

    task automatic do_reset(input int wn);
        rst    = 1'b1;
        wait_n = wn;
        repeat (3) @(negedge clk);
        chk({tag, "_rst_req"},  {31'd0, req},  32'd0);
        chk({tag, "_rst_pc"},   {24'd0, addr}, 32'd0);
        chk({tag, "_rst_acc"},  {24'd0, acc},  32'd0);
        chk({tag, "_rst_unit"}, {29'd0, unit}, 32'd7);
        chk({tag, "_rst_halt"}, {31'd0, halt}, 32'd0);
        rst     = 1'b0;
        fetches = 0;
        viol    = 0;
        n_exec  = 0;
        @(negedge clk);
        chk({tag, "_first_req"},  {31'd0, req},  32'd1);
        chk({tag, "_first_addr"}, {24'd0, addr}, 32'd0);
    endtask

    task automatic finish_run(input int budget, input int exp_fetch, input logic [7:0] exp_acc);
        int k;
        k = 0;
        while (!halt && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!halt) begin
            n_chk++;
            $display("FAIL %s_timeout: halt_out got 0 after %0d cycles, expected 1", tag, budget);
        end
        repeat (8) @(negedge clk);
        chk({tag, "_q_empty"},   exp_q.size(),  32'd0);
        chk({tag, "_idle_req"},  {31'd0, req},  32'd0);
        chk({tag, "_frz_acc"},   {24'd0, acc},  {24'd0, exp_acc});
        chk({tag, "_fetches"},   fetches,       exp_fetch);
        chk({tag, "_handshake"}, viol,          32'd0);
        exp_q.delete();
        have_cur = 1'b0;
    endtask

    initial begin
        // Arithmetic / logic, zero-wait memory
        tag = "arith";
        clear_mem();
        prog[0] = 8'hC9; prog[1] = 8'hB1; prog[2] = 8'hC5; prog[3] = 8'h11; prog[4] = 8'h01;
        prog[5] = 8'h81; prog[6] = 8'h91; prog[7] = 8'hA1; prog[8] = 8'hE0; prog[9] = 8'hF0;
        push(3'b011, 0, 0, 8'h09, 8'h01, 0, 0);
        push(3'b111, 0, 0, 8'h09, 8'h02, 0, 3);
        push(3'b011, 0, 0, 8'h05, 8'h03, 0, 3);
        push(3'b000, 1, 0, 8'hFC, 8'h04, 0, 3);
        push(3'b000, 0, 0, 8'h05, 8'h05, 0, 3);
        push(3'b100, 0, 0, 8'h0D, 8'h06, 0, 3);
        push(3'b101, 0, 0, 8'h04, 8'h07, 0, 3);
        push(3'b110, 0, 0, 8'h00, 8'h08, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h09, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h0A, 1, 3);
        do_reset(0);
        finish_run(200, 10, 8'h00);

        // Multiplier segments, signed/unsigned; r2=0xF0 built with LDI+SHL
        tag = "mul";
        clear_mem();
        prog[0]  = 8'hC4; prog[1]  = 8'hB4; prog[2]  = 8'hCF; prog[3]  = 8'h54; prog[4]  = 8'hB2;
        prog[5]  = 8'hC1; prog[6]  = 8'h54; prog[7]  = 8'hB5; prog[8]  = 8'h32; prog[9]  = 8'h75;
        prog[10] = 8'h42; prog[11] = 8'h75; prog[12] = 8'h22; prog[13] = 8'hF0;
        push(3'b011, 0, 0, 8'h04, 8'h01, 0, 0);
        push(3'b111, 0, 0, 8'h04, 8'h02, 0, 3);
        push(3'b011, 0, 0, 8'h0F, 8'h03, 0, 3);
        push(3'b010, 0, 0, 8'hF0, 8'h04, 0, 3);
        push(3'b111, 0, 0, 8'hF0, 8'h05, 0, 3);
        push(3'b011, 0, 0, 8'h01, 8'h06, 0, 3);
        push(3'b010, 0, 0, 8'h10, 8'h07, 0, 3);
        push(3'b111, 0, 0, 8'h10, 8'h08, 0, 3);
        push(3'b001, 0, 1, 8'h0F, 8'h09, 0, 3);
        push(3'b011, 0, 0, 8'h10, 8'h0A, 0, 3);
        push(3'b001, 1, 1, 8'hFF, 8'h0B, 0, 3);
        push(3'b011, 0, 0, 8'h10, 8'h0C, 0, 3);
        push(3'b001, 0, 0, 8'h00, 8'h0D, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h0E, 1, 3);
        do_reset(0);
        finish_run(200, 14, 8'h00);

        // Countdown loop closed by BNEZ -2
        tag = "loop";
        clear_mem();
        prog[0] = 8'hC1; prog[1] = 8'hB1; prog[2] = 8'hC3; prog[3] = 8'h11;
        prog[4] = 8'hE0; prog[5] = 8'hDE; prog[6] = 8'hF0;
        push(3'b011, 0, 0, 8'h01, 8'h01, 0, 0);
        push(3'b111, 0, 0, 8'h01, 8'h02, 0, 3);
        push(3'b011, 0, 0, 8'h03, 8'h03, 0, 3);
        push(3'b000, 1, 0, 8'h02, 8'h04, 0, 3);
        push(3'b111, 0, 0, 8'h02, 8'h05, 0, 3);
        push(3'b111, 0, 0, 8'h02, 8'h03, 0, 3);
        push(3'b000, 1, 0, 8'h01, 8'h04, 0, 3);
        push(3'b111, 0, 0, 8'h01, 8'h05, 0, 3);
        push(3'b111, 0, 0, 8'h01, 8'h03, 0, 3);
        push(3'b000, 1, 0, 8'h00, 8'h04, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h05, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h06, 0, 3);
        push(3'b111, 0, 0, 8'h00, 8'h07, 1, 3);
        do_reset(0);
        finish_run(300, 13, 8'h00);

        // Backward wrap BNEZ -8 from addr 2, 4-cycle memory, stray valids while not waiting
        tag = "wrap";
        clear_mem();
        prog[0] = 8'hC1; prog[1] = 8'hE0; prog[2] = 8'hD8; prog[8'hFA] = 8'hF0;
        spur = 1'b1;
        push(3'b011, 0, 0, 8'h01, 8'h01, 0, 0);
        push(3'b111, 0, 0, 8'h01, 8'h02, 0, 7);
        push(3'b111, 0, 0, 8'h01, 8'hFA, 0, 7);
        push(3'b111, 0, 0, 8'h01, 8'hFB, 1, 7);
        do_reset(4);
        finish_run(200, 4, 8'h01);
        spur = 1'b0;

        // Reset asserted while waiting on memory: clean restart at PC 0
        tag = "rstwait";
        clear_mem();
        prog[0] = 8'hC7; prog[1] = 8'hF0;
        push(3'b011, 0, 0, 8'h07, 8'h01, 0, 0);
        push(3'b111, 0, 0, 8'h07, 8'h02, 1, 7);
        do_reset(4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_req_drop", {31'd0, req}, 32'd0);
        chk("rstwait_pc", {24'd0, addr}, 32'd0);
        rst     = 1'b0;
        fetches = 0;
        viol    = 0;
        finish_run(200, 2, 8'h07);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
